// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, LSB first, through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output o_ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             o_ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0] r_cnt;
  logic r_carry, r_cout;
  logic w_accept, w_last, w_s, w_c;
  assign w_accept = i_start && r_state != RUN;
  assign w_last = r_state == RUN && r_cnt == CW'(WIDTH - 1);
  assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign o_busy = r_state == RUN;
  assign o_done = r_state == DONE;
  assign o_sum = r_sum;
  assign o_cout = r_cout;
  always_comb begin
    w_next = r_state == RUN ? (w_last ? DONE : RUN) : (i_start ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // r_a doubles as the result shift register: sum bits enter at the MSB as operand bits leave the LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_carry <= 1'b0;
      r_cnt <= '0;
      r_sum <= '0;
      r_cout <= 1'b0;
    end else if (w_accept) begin
      r_a <= i_a;
      r_b <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub | i_cin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a <= {w_s, r_a[WIDTH-1:1]};
      r_b <= r_b >> 1;
      r_carry <= w_c;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum <= {w_s, r_a[WIDTH-1:1]};
        r_cout <= w_c;
      end
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  assign o_ovf = r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_carry ^ w_c;
  end
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven vectors plus handshake and reset sequences for serial_adder, WIDTH=8.
module tb_serial_adder;
  logic clk = 0, rst = 0, i_start = 0, i_sub = 0, i_cin = 0;
  logic [7:0] i_a = 0, i_b = 0, o_sum;
  logic o_busy, o_done, o_cout;
  int total = 0, bad = 0;
`ifdef SERIAL_ADDER_OVF_EN
  logic o_ovf;
`endif
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_sub(i_sub), .i_a(i_a), .i_b(i_b),
    .i_cin(i_cin), .o_busy(o_busy), .o_done(o_done), .o_sum(o_sum), .o_cout(o_cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .o_ovf(o_ovf)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic sub;
    logic [7:0] a;
    logic [7:0] b;
    logic cin;
    logic [7:0] s;
    logic c;
    logic v;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic launch(input logic sub, input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    i_start = 1; i_sub = sub; i_a = a; i_b = b; i_cin = cin;
    @(posedge clk);
    #1 i_start = 0;
  endtask
  // counts negedges after the start edge until done; 9 means done in the cycle after edge k+8
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (o_busy) busy_cnt++;
      if (o_done) break;
    end
  endtask
  task automatic chk_res(input string name, input vec_t e);
    chk({name, ".sum"}, int'(o_sum), int'(e.s));
    chk({name, ".cout"}, int'(o_cout), int'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
    chk({name, ".ovf"}, int'(o_ovf), int'(e.v));
`endif
  endtask
  initial begin
    int lat, bc;
    v[0] = '{0, 8'h0F, 8'h01, 0, 8'h10, 0, 0};
    v[1] = '{0, 8'hFF, 8'h01, 0, 8'h00, 1, 0};
    v[2] = '{0, 8'hFF, 8'h00, 1, 8'h00, 1, 0};
    v[3] = '{1, 8'h05, 8'h07, 0, 8'hFE, 0, 0};
    v[4] = '{1, 8'h07, 8'h05, 0, 8'h02, 1, 0};
    v[5] = '{0, 8'h7F, 8'h01, 0, 8'h80, 0, 1};
    v[6] = '{1, 8'h80, 8'h01, 0, 8'h7F, 1, 1};
    v[7] = '{1, 8'h10, 8'h10, 1, 8'h00, 1, 0};
    v[8] = '{0, 8'h80, 8'h80, 0, 8'h00, 1, 1};
    v[9] = '{0, 8'hA5, 8'h5A, 1, 8'h00, 1, 0};
    #1 rst = 1;
    #1;
    chk("rst.busy", int'(o_busy), 0);
    chk("rst.done", int'(o_done), 0);
    chk_res("rst", '{0, 0, 0, 0, 8'h00, 0, 0});
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      launch(v[i].sub, v[i].a, v[i].b, v[i].cin);
      wait_done(lat, bc);
      chk($sformatf("v%0d.latency", i), lat, 9);
      chk($sformatf("v%0d.busy_cycles", i), bc, 8);
      chk_res($sformatf("v%0d", i), v[i]);
    end
    // start in RUN is ignored; sum keeps the previous result while shifting
    launch(0, 8'h01, 8'h02, 0);
    @(negedge clk);
    @(negedge clk);
    chk("run.sum_hold", int'(o_sum), 8'h00);
    i_start = 1; i_a = 8'h11; i_b = 8'h22;
    @(posedge clk);
    #1 i_start = 0;
    lat = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (o_done) break;
    end
    chk("ignore.latency", lat, 9);
    chk("ignore.sum", int'(o_sum), 8'h03);
    // start held during DONE begins the next op with no idle gap
    i_start = 1; i_sub = 0; i_a = 8'h30; i_b = 8'h0C; i_cin = 0;
    @(posedge clk);
    #1 i_start = 0;
    wait_done(lat, bc);
    chk("b2b.done_gap", lat, 9);
    chk("b2b.busy_cycles", bc, 8);
    chk("b2b.sum", int'(o_sum), 8'h3C);
    @(negedge clk);
    chk("b2b.done_pulse", int'(o_done), 0);
    // asynchronous reset mid-operation
    launch(0, 8'h0F, 8'hF0, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst.busy", int'(o_busy), 0);
    chk("arst.done", int'(o_done), 0);
    chk_res("arst", '{0, 0, 0, 0, 8'h00, 0, 0});
    @(negedge clk);
    rst = 0;
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_done) bc++;
    end
    chk("arst.no_done", bc, 0);
    launch(0, 8'h03, 8'h04, 0);
    wait_done(lat, bc);
    chk("arst.after.latency", lat, 9);
    chk_res("arst.after", '{0, 0, 0, 0, 8'h07, 0, 0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  request new operation; sampled only when idle or done.
REQ-005 sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 cin  input  1  carry in for add; sampled with start; ignored when sub=1.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout  output  1  registered carry out; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  registered signed overflow; present only per REQ-030.

Function
REQ-014 Block SHALL compute the result bit-serially, LSB first, one bit per clock through a single 1-bit full-adder cell.
REQ-015 FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN.
- RUN: after WIDTH bit-steps -> DONE.
- DONE: start=1 -> RUN; else -> IDLE.
REQ-016 On accepting start: latch a; latch b (add) or ~b (sub); initialise carry to cin (add) or 1 (sub); clear bit counter.
REQ-017 Each RUN edge: sum_bit = a_i ^ b_i ^ carry, carry = majority(a_i, b_i, carry); shift the result into an internal shift register; increment the counter.
REQ-018 Counter SHALL be ceil(log2(WIDTH+1)) bits wide; it leaves RUN on the edge that processes bit WIDTH-1, without wrap.
REQ-019 Latency: when start is sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH, for exactly one cycle.
REQ-020 busy SHALL be high in RUN, and low in IDLE and DONE.
REQ-021 sum, cout and ovf SHALL update only on the edge entering DONE, and SHALL hold until the next completion; internal shifting SHALL NOT be visible on sum.
REQ-022 start in RUN SHALL be ignored; operands presented then SHALL NOT be captured.
REQ-023 start in DONE SHALL be accepted with zero idle gap; back-to-back throughput is one result per WIDTH+1 cycles.
REQ-024 Arithmetic is modulo 2^WIDTH; the carry out of bit WIDTH-1 SHALL go to cout.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry and shift register, regardless of clk.
REQ-026 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN selects overflow detection.
REQ-029 Without the macro: port ovf SHALL be absent, and no overflow logic SHALL be built.
REQ-030 With the macro: port ovf SHALL exist, computed as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), and registered per REQ-021.

Verification (WIDTH=8, SERIAL_ADDER_OVF_EN defined)
REQ-031 Add: a=8'h0F, b=8'h01, cin=0 -> done 8 edges after start; sum=8'h10, cout=0, ovf=0; busy high for exactly 8 cycles.
REQ-032 Wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. With cin=1 and b=8'h00 -> sum=8'h00, cout=1.
REQ-033 Subtract: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0. Then a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
REQ-034 Overflow: a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, ovf=1. Also sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, ovf=1.
REQ-035 Handshake:
- start with 8'h11+8'h22 in RUN (3 cycles after the first start) -> ignored; first result unchanged.
- start held high in the DONE cycle -> new operation begins; next done 9 cycles after the previous done.
REQ-036 Reset mid-op: assert rst 4 cycles into RUN, asynchronously between edges -> outputs zero immediately; no done; a subsequent 8'h03+8'h04 gives 8'h07.
